// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with terminal-count tick
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TERM);

    // Wrap at terminal count; a clear realigns the bit grid to a frame start.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO and serialises each byte as a UART frame
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    import fifo_uart_pkg::*;

    localparam logic PAR_ON = (PARITY != PAR_NONE);

    state_e     state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_q, stop_d;
    logic       tx_q, tx_d;
    logic       rd_q, rd_d;
    logic       tick;
    logic       clear;
    logic       last_stop;
    logic       do_load;
    logic       par_bit;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .clear(clear),
        .tick (tick)
    );

    assign last_stop  = (state_q == ST_STOP) && tick && (stop_q == 1'(STOP_BITS - 1));
    assign do_load    = tx_en && !fifo_empty && ((state_q == ST_IDLE) || last_stop);
    assign par_bit    = (PARITY == PAR_EVEN) ? (^sh_q) : ~(^sh_q);
    assign busy       = (state_q != ST_IDLE);
    assign tx         = tx_q;
    assign fifo_rd_en = rd_q;

    // Frame sequencing: advance on bit ticks, reload straight from the last stop cycle.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        tx_d       = tx_q;
        rd_d       = 1'b0;
        clear      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    tx_d    = sh_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        if (PAR_ON) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = ST_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = sh_q[idx_q + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // A load overrides whatever the current state decided.
        if (do_load) begin
            state_d = ST_START;
            sh_d    = fifo_data;
            idx_d   = 3'd0;
            stop_d  = 1'b0;
            tx_d    = 1'b0;
            rd_d    = 1'b1;
            clear   = 1'b1;
        end
    end

    // State, datapath and output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sh_q    <= 8'h00;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized model-checked bench for three transmitter configurations
module tb_fifo_uart_tx;

    logic       clk;
    logic       rstn;
    logic       tx_en;
    logic       fe     [3];
    logic [7:0] fd     [3];
    logic       rd_w   [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic       done_w [3];

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fe[0]), .fifo_data(fd[0]),
        .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fe[1]), .fifo_data(fd[1]),
        .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fe[2]), .fifo_data(fd[2]),
        .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

    // Per-instance configuration.
    function automatic int cpb(int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic int par(int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction
    function automatic int stb(int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int flen(int i);
        return cpb(i) * (10 + ((par(i) != 0) ? 1 : 0) + stb(i) - 1);
    endfunction

    // Whole frame as a bit vector, bit k sent during bit-time k.
    function automatic logic [11:0] frame_bits(int i, logic [7:0] d);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (par(i) == 1) b[9] = ^d;
        else if (par(i) == 2) b[9] = ~(^d);
        return b;
    endfunction

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pos [3];
    logic [11:0] fb [3];
    logic [7:0]  fq [3][$];
    bit          pop_req [3];
    int          busy_cnt [3];
    int          rd_cnt [3];
    int          done_at [3];
    logic        txlog [3][128];
    int          rd_at [3][4];
    logic        etx, ebusy, erd, edone;
    logic [9:0]  seq_a5;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0d, want %0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic refresh(input int i);
        fe[i] = (fq[i].size() == 0);
        fd[i] = fe[i] ? 8'($urandom) : fq[i][0];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] d);
        if (fq[i].size() < 32) fq[i].push_back(d);
        refresh(i);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            rd_cnt[i]   = 0;
            done_at[i]  = -1;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rstn) pos[i] = -1;
            if (pos[i] < 0) begin
                etx = 1'b1; ebusy = 1'b0; erd = 1'b0; edone = 1'b0;
            end else begin
                etx   = fb[i][pos[i] / cpb(i)];
                ebusy = 1'b1;
                erd   = (pos[i] == 0);
                edone = (pos[i] == flen(i) - 1);
            end
            chk("tx", i, tx_w[i], etx);
            chk("busy", i, busy_w[i], ebusy);
            chk("rd_en", i, rd_w[i], erd);
            chk("frame_done", i, done_w[i], edone);
            pop_req[i] = (rd_w[i] === 1'b1);
            if (rstn) begin
                if (busy_w[i]) begin
                    if (busy_cnt[i] < 128) txlog[i][busy_cnt[i]] = tx_w[i];
                    busy_cnt[i]++;
                end
                if (done_w[i]) done_at[i] = busy_cnt[i];
                if (rd_w[i]) begin
                    if (rd_cnt[i] < 4) rd_at[i][rd_cnt[i]] = cyc;
                    rd_cnt[i]++;
                end
                if (((pos[i] < 0) || (pos[i] == flen(i) - 1)) && tx_en && (fq[i].size() > 0)) begin
                    fb[i]  = frame_bits(i, fq[i][0]);
                    pos[i] = 0;
                end else if (pos[i] == flen(i) - 1) begin
                    pos[i] = -1;
                end else if (pos[i] >= 0) begin
                    pos[i]++;
                end
            end
        end
    end

    // FIFO read side: pop after a cycle in which rd_en was high.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pop_req[i]) begin
                pop_req[i] = 1'b0;
                if (fq[i].size() > 0) void'(fq[i].pop_front());
            end
            refresh(i);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int r;
        int n;
        seq_a5 = 10'b1101001010;
        rstn   = 1'b0;
        tx_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1;
            pop_req[i] = 1'b0;
            refresh(i);
        end
        clear_logs();
        step(3);
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", i, tx_w[i], 1);
            chk("rst_busy", i, busy_w[i], 0);
            chk("rst_rd", i, rd_w[i], 0);
        end
        rstn = 1'b1;
        step(2);

        // Single frames
        push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07);
        clear_logs();
        tx_en = 1'b1;
        step(60);
        for (int c = 0; c < 40; c++) chk("a5_bits", 0, txlog[0][c], seq_a5[c / 4]);
        chk("a5_busy", 0, busy_cnt[0], 40);
        chk("a5_done", 0, done_at[0], 40);
        chk("a5_pops", 0, rd_cnt[0], 1);
        chk("odd_busy", 1, busy_cnt[1], 44);
        chk("odd_done", 1, done_at[1], 44);
        for (int c = 36; c < 40; c++) chk("odd_par", 1, txlog[1][c], 0);
        for (int c = 40; c < 44; c++) chk("odd_stop", 1, txlog[1][c], 1);
        chk("even_busy", 2, busy_cnt[2], 24);
        chk("even_done", 2, done_at[2], 24);
        chk("even_d7", 2, txlog[2][17], 0);
        for (int c = 18; c < 20; c++) chk("even_par", 2, txlog[2][c], 1);
        for (int c = 20; c < 24; c++) chk("stop2", 2, txlog[2][c], 1);

        // Back-to-back frames
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            push(i, 8'h11); push(i, 8'h22); push(i, 8'h33);
        end
        step(140);
        chk("b2b_busy", 0, busy_cnt[0], 120);
        chk("b2b_busy", 1, busy_cnt[1], 132);
        chk("b2b_busy", 2, busy_cnt[2], 72);
        chk("b2b_gap1", 0, rd_at[0][1] - rd_at[0][0], 40);
        chk("b2b_gap2", 0, rd_at[0][2] - rd_at[0][0], 80);
        chk("b2b_gap1", 1, rd_at[1][1] - rd_at[1][0], 44);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_pops", i, rd_cnt[i], 3);
            chk("b2b_empty", i, fq[i].size(), 0);
        end

        // Held off by tx_en, then tx_en dropped mid-frame
        tx_en = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            push(i, 8'h5A); push(i, 8'hC3);
        end
        clear_logs();
        step(200);
        for (int i = 0; i < 3; i++) begin
            chk("hold_busy", i, busy_cnt[i], 0);
            chk("hold_pops", i, rd_cnt[i], 0);
        end
        tx_en = 1'b1;
        step(3);
        tx_en = 1'b0;
        step(60);
        for (int i = 0; i < 3; i++) begin
            chk("drop_pops", i, rd_cnt[i], 1);
            chk("drop_left", i, fq[i].size(), 1);
        end
        chk("drop_busy", 0, busy_cnt[0], 40);
        chk("drop_busy", 1, busy_cnt[1], 44);
        chk("drop_busy", 2, busy_cnt[2], 24);

        // Reset during data bit 3 of instance 0
        tx_en = 1'b1;
        g = 0;
        while (pos[0] != 18 && g < 100) begin
            step(1);
            g++;
        end
        chk("rst_reach", 0, (g < 100) ? 1 : 0, 1);
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_tx", i, tx_w[i], 1);
            chk("midrst_busy", i, busy_w[i], 0);
        end
        step(1);
        for (int i = 0; i < 3; i++) push(i, 8'h3C);
        clear_logs();
        step(1);
        rstn = 1'b1;
        step(60);
        chk("fresh_busy", 0, busy_cnt[0], 40);
        chk("fresh_pops", 0, rd_cnt[0], 1);
        chk("fresh_start", 0, txlog[0][0], 0);
        chk("fresh_d0", 0, txlog[0][4], 0);
        chk("fresh_d2", 0, txlog[0][12], 1);

        // Randomized traffic
        for (int it = 0; it < 800; it++) begin
            r = $urandom_range(0, 7);
            if (r < 3) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) push($urandom_range(0, 2), 8'($urandom));
            end
            if ($urandom_range(0, 7) == 0) tx_en = ~tx_en;
            step($urandom_range(1, 12));
        end
        tx_en = 1'b1;
        g = 0;
        while (((fq[0].size() + fq[1].size() + fq[2].size()) != 0 ||
                pos[0] >= 0 || pos[1] >= 0 || pos[2] >= 0) && g < 6000) begin
            step(1);
            g++;
        end
        chk("drained", 0, (g < 6000) ? 1 : 0, 1);
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
